// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding instruction fetch sequencer with redirect kill
// and a decode-facing output register.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_branch_flag,
    input  logic [31:0] jump_branch_addr,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);
    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        slot_free, fire, load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0;
            kill_q    <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            kill_q    <= kill_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // A redirect never blocks the state transition; it only marks the in-flight fetch dead.
    always_comb begin
        fire      = mem_req_o && mem_gnt_i;
        load      = (state_q == S_WAIT) && mem_rvalid_i && !kill_q && !jump_branch_flag;
        state_d   = (state_q == S_REQ) ? (fire ? S_WAIT : S_REQ)
                                       : (mem_rvalid_i ? S_REQ : S_WAIT);
        kill_d    = (state_q == S_REQ) ? (jump_branch_flag && fire)
                                       : (!mem_rvalid_i && (kill_q || jump_branch_flag));
        pc_d      = jump_branch_flag ? (jump_branch_addr & ~32'h3)
                  : fire             ? pc_q + 32'd4
                  :                    pc_q;
        pend_pc_d = fire ? pc_q : pend_pc_q;
        valid_d   = jump_branch_flag       ? 1'b0
                  : load                   ? 1'b1
                  : (valid_q && !stall_i)  ? 1'b0
                  :                          valid_q;
        inst_d    = load ? mem_rdata_i : inst_q;
        inst_pc_d = load ? pend_pc_q : inst_pc_q;
    end

    always_comb begin
        slot_free    = !valid_q || !stall_i;
        mem_req_o    = rst && (state_q == S_REQ) && slot_free;
        mem_addr_o   = pc_q;
        inst_valid_o = valid_q;
        inst_o       = inst_q;
        inst_pc_o    = inst_pc_q;
    end
endmodule
